// File: rtl/cdc_hs_src.sv
// cdc_hs_src
// ----------
// Source-side end of a two-phase (toggle) request/acknowledge CDC handshake.
// A word accepted from a valid/ready producer is registered onto cdc_data.
// cdc_req then toggles toward the destination domain. The block holds both
// until the destination's acknowledge toggle, resynchronized internally,
// matches cdc_req in parity. Only then is the next word accepted.
//
// Handshake: a word moves on every rising clk edge where in_vld && in_rdy.
// in_data is sampled only on that edge. in_vld may drop without acceptance,
// and that has no effect.
//
// Ports:
//   clk          source clock, all logic on its rising edge
//   s_rst        synchronous active-high reset
//   in_data      word to transfer (DATA_W)
//   in_vld       producer valid
//   in_rdy       block can accept a word (state IDLE)
//   cdc_data     registered word, stable while a transfer is pending
//   cdc_req      registered request toggle level to the destination domain
//   cdc_ack      acknowledge toggle level from the destination (asynchronous)
//   busy         transfer outstanding (state WAIT_ACK)
//   timeout_err  sticky acknowledge-watchdog error
//
// Build option: define CDC_HS_SRC_TIMEOUT_EN to enable the acknowledge
// watchdog. It sets timeout_err after TIMEOUT_CYCLES WAIT_ACK cycles. Without
// the macro, timeout_err is constant 0.

module cdc_hs_src #(
    parameter int DATA_W         = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              s_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] cdc_data,
    output logic              cdc_req,
    input  logic              cdc_ack,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;
    logic                   accept;

    // The first chain flop is the only point that samples the asynchronous
    // cdc_ack. Only the last flop feeds the parity compare.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], cdc_ack};
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];
    assign accept   = in_vld & in_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Ack parity is examined only in WAIT_ACK, so an ack
    // toggle that arrives while idle is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (in_vld)              state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_sync == cdc_req) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_rdy = (state == IDLE);
        busy   = (state == WAIT_ACK);
    end

    // Data/request registers change only on accept. A reset abandons any
    // pending transfer and returns cdc_req to 0.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            cdc_data <= '0;
            cdc_req  <= 1'b0;
        end else if (accept) begin
            cdc_data <= in_data;
            cdc_req  <= ~cdc_req;
        end
    end

`ifdef CDC_HS_SRC_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_inc;
    logic             err_q;

    assign wd_cnt_inc = wd_cnt + CNT_W'(1);

    // The counter saturates at the limit. The error flag is sticky until
    // reset. The FSM keeps waiting, so a late ack still completes the transfer.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            wd_cnt <= '0;
        end else if (state == WAIT_ACK && wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt_inc;
            if (wd_cnt_inc == CNT_MAX) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    // The watchdog is absent. The limit parameter appears here only so that
    // it stays referenced. The expression is constant 0.
    assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_cdc_hs_src.sv
// Testbench for cdc_hs_src (DATA_W=32, SYNC_STAGES=2, TIMEOUT_CYCLES=16).
// The ack source is selectable: manual level, combinational loopback of
// cdc_req, or a destination model that returns the toggle 7 cycles late.
// A negedge monitor pops the expected queue on every cdc_req toggle.

module tb_cdc_hs_src;

    localparam int DW = 32;

`ifdef CDC_HS_SRC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          s_rst;
    logic [DW-1:0] in_data;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] cdc_data;
    logic          cdc_req;
    logic          cdc_ack;
    logic          busy;
    logic          timeout_err;

    // ack source: 0 = manual, 1 = loopback, 2 = delayed destination model
    int            ack_mode;
    logic          ack_man;
    logic          ack_dly;

    int            checks;
    int            passes;
    logic [DW-1:0] exp_q[$];

    // monitor state
    logic          prev_req;
    logic          prev_busy;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_w;
    int            tog_cnt;
    int            stab_err;
    int            dly_cnt;
    bit            toggled;

    assign cdc_ack = (ack_mode == 1) ? cdc_req :
                     (ack_mode == 2) ? ack_dly : ack_man;

    cdc_hs_src #(
        .DATA_W        (DW),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .s_rst      (s_rst),
        .in_data    (in_data),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .cdc_data   (cdc_data),
        .cdc_req    (cdc_req),
        .cdc_ack    (cdc_ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- monitor / scoreboard + destination model ----------------
    initial begin
        prev_req  = 1'b0;
        prev_busy = 1'b0;
        prev_data = '0;
        tog_cnt   = 0;
        stab_err  = 0;
        dly_cnt   = 0;
        ack_dly   = 1'b0;
    end

    always @(negedge clk) begin
        if (s_rst) begin
            prev_req  = 1'b0;
            prev_busy = 1'b0;
            dly_cnt   = 0;
            ack_dly   = 1'b0;
        end else begin
            toggled = (cdc_req !== prev_req);
            if (toggled) begin
                tog_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard: cdc_req toggle with no word pending, cdc_data=%h", cdc_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (cdc_data !== exp_w)
                        $display("FAIL scoreboard: cdc_data=%h expected %h", cdc_data, exp_w);
                    else
                        passes++;
                end
            end else if (prev_busy && busy === 1'b1 && cdc_data !== prev_data) begin
                stab_err++;
            end
            if (ack_mode == 2) begin
                if (toggled) begin
                    dly_cnt = 7;
                end else if (dly_cnt > 0) begin
                    dly_cnt--;
                    if (dly_cnt == 0) ack_dly = cdc_req;
                end
            end
            prev_req  = cdc_req;
            prev_busy = (busy === 1'b1);
            prev_data = cdc_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Bounded wait for in_rdy; an expired budget counts as a failed check.
    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (in_rdy === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) $display("FAIL %s: in_rdy not back within %0d cycles", name, budget);
        else passes++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        s_rst = 1'b1;
        idle_cycles(3);
        s_rst = 1'b0;
        @(negedge clk);
        checks++; if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy: got %b expected 1", in_rdy); else passes++;
        checks++; if (cdc_req !== 1'b0) $display("FAIL reset_cdc_req: got %b expected 0", cdc_req); else passes++;
        checks++; if (cdc_data !== '0) $display("FAIL reset_cdc_data: got %h expected 0", cdc_data); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); else passes++;
        // a spurious ack toggle while idle must be ignored
        ack_man = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b1 || busy !== 1'b0 || cdc_req !== 1'b0)
                $display("FAIL idle_ack: in_rdy=%b busy=%b cdc_req=%b expected 1/0/0", in_rdy, busy, cdc_req);
            else passes++;
        end
        ack_man = 1'b0;
        idle_cycles(4);
    endtask

    task automatic test_loopback();
        ack_mode = 1;
        // first word: the accept edge is the next posedge (in_rdy is 1 while idle)
        in_data = 32'hDEAD_BEEF;
        in_vld  = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_data = 32'h0;
        @(negedge clk); // cycle N+1
        checks++; if (cdc_req !== 1'b1) $display("FAIL lb_req_n1: got %b expected 1", cdc_req); else passes++;
        checks++; if (cdc_data !== 32'hDEAD_BEEF) $display("FAIL lb_data_n1: got %h expected deadbeef", cdc_data); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL lb_busy_n1: got %b expected 1", busy); else passes++;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); // cycles N+2..N+4
            checks++;
            if (in_rdy !== (k == 4)) $display("FAIL lb_in_rdy_n%0d: got %b expected %b", k, in_rdy, (k == 4));
            else passes++;
        end
        // second word toggles the request back to 0
        in_data = 32'h1234_5678;
        in_vld  = 1'b1;
        exp_q.push_back(32'h1234_5678);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        @(negedge clk);
        checks++; if (cdc_req !== 1'b0) $display("FAIL lb_req_word2: got %b expected 0", cdc_req); else passes++;
        checks++; if (cdc_data !== 32'h1234_5678) $display("FAIL lb_data_word2: got %h expected 12345678", cdc_data); else passes++;
        wait_idle("lb_word2_done", 10);
        ack_mode = 0;
        ack_man  = cdc_req;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words[8];
        bit            got;
        words[0] = 32'h0000_0000;
        words[7] = 32'hFFFF_FFFF;
        for (int i = 1; i < 7; i++) words[i] = $urandom;
        tog_cnt  = 0;
        stab_err = 0;
        ack_mode = 2;
        in_vld   = 1'b1;
        for (int w = 0; w < 8; w++) begin
            in_data = words[w];
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (in_rdy === 1'b1) begin
                    exp_q.push_back(words[w]);
                    got = 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
            checks++;
            if (!got) $display("FAIL b2b_accept_%0d: in_rdy never seen, got 0 expected 1", w);
            else passes++;
        end
        in_vld = 1'b0;
        wait_idle("b2b_done", 40);
        checks++; if (tog_cnt !== 8) $display("FAIL b2b_toggles: got %0d expected 8", tog_cnt); else passes++;
        checks++; if (stab_err !== 0) $display("FAIL b2b_stable: got %0d changes while busy expected 0", stab_err); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL b2b_queue: got %0d left expected 0", exp_q.size()); else passes++;
        ack_man  = cdc_req;
        ack_mode = 0;
    endtask

    task automatic test_reset_mid();
        ack_mode = 0;
        ack_man  = 1'b0;
        in_data  = 32'hA5A5_0001;
        in_vld   = 1'b1;
        exp_q.push_back(32'hA5A5_0001);
        @(posedge clk); // accept edge
        #1;
        in_vld = 1'b0;
        @(negedge clk); // N+1: destination acks now, match would land in N+3
        checks++; if (busy !== 1'b1) $display("FAIL rm_busy: got %b expected 1", busy); else passes++;
        ack_man = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b1;   // sampled on the edge just before the match
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        @(negedge clk);
        checks++; if (in_rdy !== 1'b1) $display("FAIL rm_in_rdy: got %b expected 1", in_rdy); else passes++;
        checks++; if (cdc_req !== 1'b0) $display("FAIL rm_cdc_req: got %b expected 0", cdc_req); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rm_busy_after: got %b expected 0", busy); else passes++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b1 || busy !== 1'b0 || cdc_req !== 1'b0)
                $display("FAIL rm_late_ack: in_rdy=%b busy=%b cdc_req=%b expected 1/0/0", in_rdy, busy, cdc_req);
            else passes++;
        end
        // destination side reset alongside: its ack level returns to 0
        ack_man = 1'b0;
        idle_cycles(4);
    endtask

    task automatic test_timeout();
        logic exp_err;
        ack_mode = 0;
        ack_man  = cdc_req;
        in_data  = 32'hC0FF_EE00;
        in_vld   = 1'b1;
        exp_q.push_back(32'hC0FF_EE00);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); // WAIT_ACK cycle N+k
            exp_err = TO_EN && (k >= 17);
            checks++;
            if (timeout_err !== exp_err) $display("FAIL to_err_n%0d: got %b expected %b", k, timeout_err, exp_err);
            else passes++;
            checks++;
            if (busy !== 1'b1) $display("FAIL to_busy_n%0d: got %b expected 1", k, busy);
            else passes++;
        end
        ack_man = ~ack_man;
        wait_idle("to_ack_done", 10);
        checks++; if (busy !== 1'b0) $display("FAIL to_busy_done: got %b expected 0", busy); else passes++;
        checks++; if (timeout_err !== TO_EN) $display("FAIL to_err_sticky: got %b expected %b", timeout_err, TO_EN); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL to_queue: got %0d left expected 0", exp_q.size()); else passes++;
        s_rst = 1'b1;
        idle_cycles(1);
        s_rst = 1'b0;
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0) $display("FAIL to_err_cleared: got %b expected 0", timeout_err); else passes++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks   = 0;
        passes   = 0;
        s_rst    = 1'b1;
        in_data  = '0;
        in_vld   = 1'b0;
        ack_mode = 0;
        ack_man  = 1'b0;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        idle_cycles(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
